// File: rtl/eth_pkg.sv
// Shared constants and types for the RGMII receive framer.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_RESYNC,
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_END,
    ST_DISCARD
  } state_t;

  // Bit positions inside frame_status and the trailer byte
  localparam int unsigned STAT_CRC_OK = 0;
  localparam int unsigned STAT_RX_ER  = 1;
  localparam int unsigned STAT_OVF    = 2;
  localparam int unsigned STAT_TRUNC  = 3;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected) advance by one byte, LSB first.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  // Bit-serial unroll of the reflected LFSR over the 8 data bits
  always_comb begin
    crc_next = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      crc_next = (crc_next >> 1) ^ (CRC_POLY & {32{crc_next[0] ^ data[i]}});
    end
  end

endmodule

// File: rtl/eth_rx_framer.sv
// RGMII rx framer: preamble/SFD check, CRC-32 check, FCS strip via a
// 4-byte delay line, payload + status trailer into the CDC fifo.
module eth_rx_framer
  import eth_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 1518,
  parameter int unsigned TRAILER_EN = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             phy_clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic [1:0]       rx_ctl,
  input  logic             fifo_full,
  output logic [7:0]       fifo_wdata,
  output logic             fifo_winc,
  output logic             frame_done,
  output logic [3:0]       frame_status,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_bad
);

  localparam int unsigned    LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic             rx_dv;
  logic             rx_er;
  state_t           state;
  logic [2:0]       pre_cnt;
  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic [31:0]      dly;
  logic [2:0]       dly_cnt;
  logic [LEN_W-1:0] len;
  logic             flag_er;
  logic             flag_ovf;
  logic             flag_trunc;
  logic [3:0]       end_status;
  logic             ifg_bad;
  logic [1:0]       bad_inc;
  logic             ok_inc;
  logic [CNT_W:0]   ok_sum;
  logic [CNT_W:0]   bad_sum;

  assign rx_dv = rx_ctl[0];
  assign rx_er = rx_ctl[1];

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (rx_data),
    .crc_next (crc_next)
  );

  // End-of-frame status and counter increments. END can both close a bad
  // frame and reject an IFG-violating byte, so frames_bad may step by two.
  always_comb begin
    end_status              = '0;
    end_status[STAT_CRC_OK] = (crc == CRC_RESIDUE);
    end_status[STAT_RX_ER]  = flag_er;
    end_status[STAT_OVF]    = flag_ovf | ((TRAILER_EN != 0) && fifo_full);
    end_status[STAT_TRUNC]  = flag_trunc;
    ifg_bad = rx_dv && (rx_data != PREAMBLE_BYTE);
    bad_inc = '0;
    ok_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ifg_bad) bad_inc = 2'd1;
      end
      ST_PREAMBLE: begin
        if (!rx_dv || (rx_data != PREAMBLE_BYTE && rx_data != SFD_BYTE)) bad_inc = 2'd1;
      end
      ST_END: begin
        if (end_status == 4'b0001) ok_inc = 1'b1;
        else bad_inc = 2'd1;
        if (ifg_bad) bad_inc = bad_inc + 2'd1;
      end
      default: ;
    endcase
    ok_sum  = {1'b0, frames_ok}  + (CNT_W + 1)'(ok_inc);
    bad_sum = {1'b0, frames_bad} + (CNT_W + 1)'(bad_inc);
  end

  // Framer FSM with registered fifo, status and counter outputs
  always_ff @(posedge phy_clk) begin
    if (!rst_n) begin
      state        <= ST_RESYNC;
      pre_cnt      <= '0;
      crc          <= '0;
      dly          <= '0;
      dly_cnt      <= '0;
      len          <= '0;
      flag_er      <= 1'b0;
      flag_ovf     <= 1'b0;
      flag_trunc   <= 1'b0;
      fifo_wdata   <= '0;
      fifo_winc    <= 1'b0;
      frame_done   <= 1'b0;
      frame_status <= '0;
      frames_ok    <= '0;
      frames_bad   <= '0;
    end else begin
      fifo_winc  <= 1'b0;
      frame_done <= 1'b0;
      frames_ok  <= ok_sum[CNT_W]  ? '1 : ok_sum[CNT_W-1:0];
      frames_bad <= bad_sum[CNT_W] ? '1 : bad_sum[CNT_W-1:0];
      case (state)
        ST_RESYNC: begin
          if (!rx_dv) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (rx_dv) begin
            if (rx_data == PREAMBLE_BYTE) begin
              state   <= ST_PREAMBLE;
              pre_cnt <= 3'd1;
            end else begin
              state <= ST_DISCARD;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!rx_dv) begin
            state <= ST_IDLE;
          end else if (rx_data == PREAMBLE_BYTE) begin
            if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
          end else if (rx_data == SFD_BYTE) begin
            state      <= ST_PAYLOAD;
            crc        <= CRC_INIT;
            dly        <= '0;
            dly_cnt    <= '0;
            len        <= '0;
            flag_er    <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_trunc <= 1'b0;
          end else begin
            state <= ST_DISCARD;
          end
        end
        ST_PAYLOAD: begin
          if (!rx_dv) begin
            state <= ST_END;
          end else begin
            crc <= crc_next;
            dly <= {dly[23:0], rx_data};
            if (rx_er) flag_er <= 1'b1;
            if (dly_cnt != 3'd4) begin
              dly_cnt <= dly_cnt + 3'd1;
            end else if (fifo_full || flag_ovf) begin
              flag_ovf <= 1'b1;
            end else if (len == LEN_MAX) begin
              flag_trunc <= 1'b1;
            end else begin
              fifo_wdata <= dly[31:24];
              fifo_winc  <= 1'b1;
              len        <= len + LEN_W'(1);
            end
          end
        end
        ST_END: begin
          frame_done   <= 1'b1;
          frame_status <= end_status;
          if ((TRAILER_EN != 0) && !fifo_full) begin
            fifo_wdata <= {4'h0, end_status};
            fifo_winc  <= 1'b1;
          end
          state <= ST_IDLE;
          if (rx_dv) begin
            if (rx_data == PREAMBLE_BYTE) begin
              state   <= ST_PREAMBLE;
              pre_cnt <= 3'd1;
            end else begin
              state <= ST_DISCARD;
            end
          end
        end
        ST_DISCARD: begin
          if (!rx_dv) state <= ST_IDLE;
        end
        default: state <= ST_RESYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Scoreboard bench for eth_rx_framer.
module tb_eth_rx_framer;

  localparam int CNT_W = 16;

  typedef logic [7:0] bq_t[$];

  logic             phy_clk = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic [1:0]       rx_ctl;
  logic             fifo_full;
  logic [7:0]       fifo_wdata;
  logic             fifo_winc;
  logic             frame_done;
  logic [3:0]       frame_status;
  logic [CNT_W-1:0] frames_ok;
  logic [CNT_W-1:0] frames_bad;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ok   = 0;
  int exp_bad  = 0;
  logic [7:0] exp_wr[$];
  logic [3:0] exp_st[$];

  always #5 phy_clk = ~phy_clk;

  eth_rx_framer #(.MAX_LEN(1518), .TRAILER_EN(1), .CNT_W(CNT_W)) dut (
    .phy_clk      (phy_clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_ctl       (rx_ctl),
    .fifo_full    (fifo_full),
    .fifo_wdata   (fifo_wdata),
    .fifo_winc    (fifo_winc),
    .frame_done   (frame_done),
    .frame_status (frame_status),
    .frames_ok    (frames_ok),
    .frames_bad   (frames_bad)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ethernet FCS: byte-wise reflected CRC-32, complemented
  function automatic logic [31:0] fcs32(input bq_t b);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t good_body();
    bq_t b;
    logic [31:0] f;
    for (int i = 0; i < 60; i++) b.push_back(8'(i));
    f = fcs32(b);
    b.push_back(f[7:0]);
    b.push_back(f[15:8]);
    b.push_back(f[23:16]);
    b.push_back(f[31:24]);
    return b;
  endfunction

  // Scoreboard consumer: every fifo write and frame_done is matched in order
  always @(negedge phy_clk) begin
    if (fifo_winc === 1'b1) begin
      if (exp_wr.size() == 0) check("wr_unexpected", {31'h0, fifo_winc}, 32'h0);
      else check("wr_data", {24'h0, fifo_wdata}, {24'h0, exp_wr.pop_front()});
    end
    if (frame_done === 1'b1) begin
      if (exp_st.size() == 0) check("done_unexpected", {31'h0, frame_done}, 32'h0);
      else check("status", {28'h0, frame_status}, {28'h0, exp_st.pop_front()});
    end
  end

  task automatic drive(input bit dv, input bit er, input logic [7:0] d, input bit full);
    @(negedge phy_clk);
    rx_ctl    = {er, dv};
    rx_data   = d;
    fifo_full = full;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_ok"},  32'(frames_ok),  32'(exp_ok));
    check({tag, "_bad"}, 32'(frames_bad), 32'(exp_bad));
  endtask

  // Sends preamble+SFD+body; models the expected writes/status up front.
  // full window is in payload write-slot indices; rst_at is a body index.
  task automatic send_frame(input string tag, input bq_t body, input int er_idx,
                            input int full_lo, input int full_hi, input int rst_at);
    int n = body.size();
    bit ovf = 1'b0;
    bit crc_ok = 1'b0;
    bit er = (er_idx >= 0 && er_idx < n);
    bq_t pl;
    logic [31:0] f;
    logic [3:0] st;
    if (n >= 4) begin
      for (int i = 0; i < n - 4; i++) pl.push_back(body[i]);
      f = fcs32(pl);
      crc_ok = (body[n-4] == f[7:0]) && (body[n-3] == f[15:8]) &&
               (body[n-2] == f[23:16]) && (body[n-1] == f[31:24]);
    end
    for (int k = 0; k < n - 4; k++) begin
      if (rst_at >= 0 && k + 4 >= rst_at) break;
      if (k >= full_lo && k <= full_hi) ovf = 1'b1;
      else if (!ovf) exp_wr.push_back(body[k]);
    end
    st = {1'b0, ovf, er, crc_ok};
    if (rst_at < 0) begin
      exp_wr.push_back({4'h0, st});
      exp_st.push_back(st);
      if (st == 4'b0001) exp_ok++;
      else exp_bad++;
    end
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'hD5, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, i == er_idx, body[i], (i - 4 >= full_lo) && (i - 4 <= full_hi));
      rst_n = (i == rst_at) ? 1'b0 : 1'b1;
      if (rst_at >= 0 && i == rst_at + 1) begin
        check("rst_winc",   {31'h0, fifo_winc}, 32'h0);
        check("rst_wdata",  {24'h0, fifo_wdata}, 32'h0);
        check("rst_done",   {31'h0, frame_done}, 32'h0);
        check("rst_status", {28'h0, frame_status}, 32'h0);
        exp_ok  = 0;
        exp_bad = 0;
        check_counters("rst_cnt");
      end
    end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    check_counters(tag);
    check({tag, "_wr_left"}, 32'(exp_wr.size()), 32'h0);
  endtask

  initial begin
    bq_t b;
    rst_n     = 1'b0;
    rx_ctl    = '0;
    rx_data   = '0;
    fifo_full = 1'b0;
    repeat (3) @(negedge phy_clk);
    check("reset_winc",   {31'h0, fifo_winc}, 32'h0);
    check("reset_wdata",  {24'h0, fifo_wdata}, 32'h0);
    check("reset_done",   {31'h0, frame_done}, 32'h0);
    check("reset_status", {28'h0, frame_status}, 32'h0);
    check_counters("reset");
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);

    b = good_body();
    send_frame("good", b, -1, -1, -1, -1);

    b = good_body();
    b[63] = b[63] ^ 8'h01;
    send_frame("badfcs", b, -1, -1, -1, -1);

    b = good_body();
    send_frame("rxer", b, 10, -1, -1, -1);

    b = good_body();
    send_frame("full", b, -1, 20, 24, -1);

    drive(1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'h12, 1'b0);
    drive(1'b1, 1'b0, 8'h34, 1'b0);
    drive(1'b1, 1'b0, 8'hD5, 1'b0);
    exp_bad++;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    check_counters("badpre");

    b = '{8'hAA, 8'hBB, 8'hCC};
    send_frame("short", b, -1, -1, -1, -1);

    b = good_body();
    send_frame("reset_mid", b, -1, -1, -1, 30);

    b = good_body();
    send_frame("after_rst", b, -1, -1, -1, -1);

    check("wr_queue_empty", 32'(exp_wr.size()), 32'h0);
    check("st_queue_empty", 32'(exp_st.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
